// File: rtl/fp_scoreboard_ctr_if.sv
// Issue, write-back and lookup bundle between decode, the write-back mux and the
// register-busy scoreboard. Decode side is master, scoreboard is slave.
interface fp_scoreboard_ctr_if #(
  parameter int TOTAL_REGS = 32,
  parameter int NUM_SRCS   = 3,
  parameter int NUM_WB     = 2,
  parameter int NUM_QRY    = 3
);
  localparam int AW = $clog2(TOTAL_REGS);

  logic                               flush;
  logic                               issue_valid;
  logic                               issue_wr;
  logic [AW-1:0]                      issue_rd;
  logic [NUM_SRCS-1:0][AW-1:0]        src_addr;
  logic [NUM_SRCS-1:0]                src_used;
  logic [NUM_SRCS-1:0][1:0]           src_fwd;
  logic [NUM_WB-1:0]                  wb_valid;
  logic [NUM_WB-1:0][AW-1:0]          wb_addr;
  logic [NUM_QRY-1:0][AW-1:0]         qry_addr;

  logic                               issue_accept;
  logic                               stall;
  logic                               no_dependency;
  logic [TOTAL_REGS-1:0]              busy_vec;
  logic [NUM_QRY-1:0]                 qry_busy;
  logic                               err_underflow;

  modport master (
    output flush, issue_valid, issue_wr, issue_rd, src_addr, src_used, src_fwd,
           wb_valid, wb_addr, qry_addr,
    input  issue_accept, stall, no_dependency, busy_vec, qry_busy, err_underflow
  );

  modport slave (
    input  flush, issue_valid, issue_wr, issue_rd, src_addr, src_used, src_fwd,
           wb_valid, wb_addr, qry_addr,
    output issue_accept, stall, no_dependency, busy_vec, qry_busy, err_underflow
  );
endinterface

// File: rtl/fp_scoreboard_ctr.sv
// Register-busy scoreboard with saturating per-register pending-write counters,
// multi-port write-back retirement, flush squash and a sticky underflow flag.
module fp_scoreboard_ctr #(
  parameter int TOTAL_REGS     = 32,
  parameter int NUM_SRCS       = 3,
  parameter int NUM_WB         = 2,
  parameter int CNT_W          = 2,
  parameter int NUM_QRY        = 3,
  parameter int ZERO_HARDWIRED = 0
) (
  input  logic             clk,
  input  logic             reset,
  fp_scoreboard_ctr_if.slave sb
);
  localparam int              AW        = $clog2(TOTAL_REGS);
  localparam int              SW        = CNT_W + 2;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [SW-1:0]    ONE      = SW'(1);
  localparam bit               HARD_ZERO = (ZERO_HARDWIRED != 0);

  logic [CNT_W-1:0]      cnt      [TOTAL_REGS];
  logic [CNT_W-1:0]      cnt_next [TOTAL_REGS];
  logic [TOTAL_REGS-1:0] under;
  logic [TOTAL_REGS-1:0] busy;
  logic [NUM_SRCS-1:0]   src_busy;
  logic [NUM_SRCS-1:0]   src_block;
  logic [NUM_QRY-1:0]    qry_hit;
  logic                  full_rd;
  logic                  stall;
  logic                  accept;
  logic                  err;

  // Forwarding only hides a busy source from the stall, not from no_dependency.
  always_comb begin
    src_busy  = '0;
    src_block = '0;
    for (int j = 0; j < NUM_SRCS; j++) begin
      src_busy[j]  = sb.src_used[j] && busy[sb.src_addr[j]];
      src_block[j] = src_busy[j] && (sb.src_fwd[j] == 2'b00);
    end
  end

  always_comb begin
    full_rd = sb.issue_wr && (cnt[sb.issue_rd] == CNT_MAX);
    if (HARD_ZERO && (sb.issue_rd == '0)) begin
      full_rd = 1'b0;
    end
  end

  assign stall  = sb.issue_valid && ((|src_block) || full_rd);
  assign accept = sb.issue_valid && !stall && !sb.flush;

  always_comb begin
    qry_hit = '0;
    for (int q = 0; q < NUM_QRY; q++) begin
      qry_hit[q] = busy[sb.qry_addr[q]];
    end
  end

  for (genvar r = 0; r < TOTAL_REGS; r++) begin : g_reg
    if (HARD_ZERO && (r == 0)) begin : g_zero
      assign cnt_next[r] = '0;
      assign under[r]    = 1'b0;
      assign busy[r]     = 1'b0;
    end else begin : g_cnt
      logic [SW-1:0] sum;

      // Signed-in-spirit sum: the extra top bit goes high when retirements outnumber writers.
      always_comb begin
        sum = {2'b00, cnt[r]};
        if (accept && sb.issue_wr && (sb.issue_rd == AW'(r))) begin
          sum = sum + ONE;
        end
        for (int k = 0; k < NUM_WB; k++) begin
          if (sb.wb_valid[k] && (sb.wb_addr[k] == AW'(r))) begin
            sum = sum - ONE;
          end
        end
      end

      assign under[r]    = sum[SW-1];
      assign cnt_next[r] = sum[SW-1] ? '0 : sum[CNT_W-1:0];
      assign busy[r]     = (cnt[r] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < TOTAL_REGS; r++) begin
        cnt[r] <= '0;
      end
      err <= 1'b0;
    end else if (sb.flush) begin
      for (int r = 0; r < TOTAL_REGS; r++) begin
        cnt[r] <= '0;
      end
    end else begin
      for (int r = 0; r < TOTAL_REGS; r++) begin
        cnt[r] <= cnt_next[r];
      end
      if (|under) begin
        err <= 1'b1;
      end
    end
  end

  assign sb.issue_accept  = accept;
  assign sb.stall         = stall;
  assign sb.no_dependency = ~|src_busy;
  assign sb.busy_vec      = busy;
  assign sb.qry_busy      = qry_hit;
  assign sb.err_underflow = err;
endmodule

// File: tb/tb_fp_scoreboard_ctr.sv
// Directed bench for fp_scoreboard_ctr: one tracked-f0 instance and one
// hardwired-x0 instance, each scenario checked against hand-computed values.
module tb_fp_scoreboard_ctr;
  localparam int TOTAL_REGS = 32;
  localparam int NUM_SRCS   = 3;
  localparam int NUM_WB     = 2;
  localparam int CNT_W      = 2;
  localparam int NUM_QRY    = 3;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fp_scoreboard_ctr_if #(.TOTAL_REGS(TOTAL_REGS), .NUM_SRCS(NUM_SRCS), .NUM_WB(NUM_WB),
                         .NUM_QRY(NUM_QRY)) bus ();
  fp_scoreboard_ctr_if #(.TOTAL_REGS(TOTAL_REGS), .NUM_SRCS(NUM_SRCS), .NUM_WB(NUM_WB),
                         .NUM_QRY(NUM_QRY)) bus_z ();

  fp_scoreboard_ctr #(.TOTAL_REGS(TOTAL_REGS), .NUM_SRCS(NUM_SRCS), .NUM_WB(NUM_WB),
                      .CNT_W(CNT_W), .NUM_QRY(NUM_QRY), .ZERO_HARDWIRED(0)) dut (
    .clk(clk), .reset(reset), .sb(bus.slave));

  fp_scoreboard_ctr #(.TOTAL_REGS(TOTAL_REGS), .NUM_SRCS(NUM_SRCS), .NUM_WB(NUM_WB),
                      .CNT_W(CNT_W), .NUM_QRY(NUM_QRY), .ZERO_HARDWIRED(1)) dut_z (
    .clk(clk), .reset(reset), .sb(bus_z.slave));

  task automatic idle();
    bus.flush = 1'b0;    bus.issue_valid = 1'b0;  bus.issue_wr = 1'b0;
    bus.issue_rd = '0;   bus.src_addr = '0;       bus.src_used = '0;
    bus.src_fwd = '0;    bus.wb_valid = '0;       bus.wb_addr = '0;
    bus.qry_addr = '0;
    bus_z.flush = 1'b0;  bus_z.issue_valid = 1'b0; bus_z.issue_wr = 1'b0;
    bus_z.issue_rd = '0; bus_z.src_addr = '0;      bus_z.src_used = '0;
    bus_z.src_fwd = '0;  bus_z.wb_valid = '0;      bus_z.wb_addr = '0;
    bus_z.qry_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_to(input logic [4:0] rd);
    bus.issue_valid = 1'b1;
    bus.issue_wr    = 1'b1;
    bus.issue_rd    = rd;
    tick();
    idle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    bus.issue_valid = 1'b1; bus.issue_wr = 1'b1; bus.issue_rd = 5'd9; bus.wb_valid = 2'b11;
    tick();
    tick();
    reset = 1'b0;
    idle();
    bus.issue_valid = 1'b1;
    #1;
    checks++; if (bus.busy_vec !== 32'h0) begin errors++;
      $display("[TB] FAIL reset_busy_vec: got %h expected 00000000", bus.busy_vec); end
    checks++; if (bus.qry_busy !== 3'b000) begin errors++;
      $display("[TB] FAIL reset_qry_busy: got %b expected 000", bus.qry_busy); end
    checks++; if (bus.no_dependency !== 1'b1) begin errors++;
      $display("[TB] FAIL reset_no_dependency: got %b expected 1", bus.no_dependency); end
    checks++; if (bus.stall !== 1'b0) begin errors++;
      $display("[TB] FAIL reset_stall: got %b expected 0", bus.stall); end
    checks++; if (bus.issue_accept !== 1'b1) begin errors++;
      $display("[TB] FAIL reset_issue_accept: got %b expected 1", bus.issue_accept); end
    checks++; if (bus.err_underflow !== 1'b0) begin errors++;
      $display("[TB] FAIL reset_err_underflow: got %b expected 0", bus.err_underflow); end
    idle();
  endtask

  task automatic test_issue_wb();
    bus.issue_valid = 1'b1; bus.issue_wr = 1'b1; bus.issue_rd = 5'd5;
    #1;
    checks++; if (bus.issue_accept !== 1'b1) begin errors++;
      $display("[TB] FAIL issue5_accept: got %b expected 1", bus.issue_accept); end
    tick();
    idle();
    bus.qry_addr[0] = 5'd5; bus.qry_addr[1] = 5'd6;
    #1;
    checks++; if (bus.busy_vec !== 32'h0000_0020) begin errors++;
      $display("[TB] FAIL issue5_busy_vec: got %h expected 00000020", bus.busy_vec); end
    checks++; if (bus.qry_busy !== 3'b001) begin errors++;
      $display("[TB] FAIL issue5_qry_busy: got %b expected 001", bus.qry_busy); end
    bus.wb_valid[0] = 1'b1; bus.wb_addr[0] = 5'd5;
    #1;
    checks++; if (bus.busy_vec !== 32'h0000_0020) begin errors++;
      $display("[TB] FAIL wb5_no_bypass: got %h expected 00000020", bus.busy_vec); end
    tick();
    idle();
    #1;
    checks++; if (bus.busy_vec !== 32'h0) begin errors++;
      $display("[TB] FAIL wb5_cleared: got %h expected 00000000", bus.busy_vec); end
  endtask

  task automatic test_src_block();
    issue_to(5'd7);
    bus.issue_valid = 1'b1; bus.src_addr[0] = 5'd7; bus.src_used = 3'b001; bus.src_fwd = '0;
    #1;
    checks++; if (bus.stall !== 1'b1) begin errors++;
      $display("[TB] FAIL src_block_stall: got %b expected 1", bus.stall); end
    checks++; if (bus.issue_accept !== 1'b0) begin errors++;
      $display("[TB] FAIL src_block_accept: got %b expected 0", bus.issue_accept); end
    checks++; if (bus.no_dependency !== 1'b0) begin errors++;
      $display("[TB] FAIL src_block_nodep: got %b expected 0", bus.no_dependency); end
    bus.src_fwd[0] = 2'b01;
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++;
      $display("[TB] FAIL src_fwd_stall: got %b expected 0", bus.stall); end
    checks++; if (bus.no_dependency !== 1'b0) begin errors++;
      $display("[TB] FAIL src_fwd_nodep: got %b expected 0", bus.no_dependency); end
    bus.src_fwd[0] = 2'b00; bus.src_used = 3'b000;
    #1;
    checks++; if ({bus.stall, bus.no_dependency} !== 2'b01) begin errors++;
      $display("[TB] FAIL src_unused: got stall/nodep %b expected 01",
               {bus.stall, bus.no_dependency}); end
    bus.src_used = 3'b100; bus.src_addr[2] = 5'd7;
    #1;
    checks++; if (bus.stall !== 1'b1) begin errors++;
      $display("[TB] FAIL src_rs3_stall: got %b expected 1", bus.stall); end
    idle();
    bus.wb_valid[1] = 1'b1; bus.wb_addr[1] = 5'd7;
    tick();
    idle();
    #1;
    checks++; if (bus.busy_vec !== 32'h0) begin errors++;
      $display("[TB] FAIL src_cleanup: got %h expected 00000000", bus.busy_vec); end
  endtask

  task automatic test_waw_limit();
    for (int i = 0; i < 3; i++) begin
      bus.issue_valid = 1'b1; bus.issue_wr = 1'b1; bus.issue_rd = 5'd3;
      #1;
      checks++; if (bus.issue_accept !== 1'b1) begin errors++;
        $display("[TB] FAIL waw_fill_%0d: got %b expected 1", i, bus.issue_accept); end
      tick();
    end
    #1;
    checks++; if ({bus.stall, bus.issue_accept} !== 2'b10) begin errors++;
      $display("[TB] FAIL waw_full: got stall/accept %b expected 10",
               {bus.stall, bus.issue_accept}); end
    tick();
    bus.wb_valid[0] = 1'b1; bus.wb_addr[0] = 5'd3;
    #1;
    checks++; if (bus.stall !== 1'b1) begin errors++;
      $display("[TB] FAIL waw_still_full: got %b expected 1", bus.stall); end
    tick();
    bus.wb_valid = '0;
    #1;
    checks++; if ({bus.stall, bus.issue_accept} !== 2'b01) begin errors++;
      $display("[TB] FAIL waw_after_wb: got stall/accept %b expected 01",
               {bus.stall, bus.issue_accept}); end
    tick();
    #1;
    checks++; if (bus.stall !== 1'b1) begin errors++;
      $display("[TB] FAIL waw_refull: got %b expected 1", bus.stall); end
    idle();
    bus.wb_valid = 2'b11; bus.wb_addr[0] = 5'd3; bus.wb_addr[1] = 5'd3;
    tick();
    idle();
    bus.qry_addr[0] = 5'd3;
    #1;
    checks++; if (bus.qry_busy[0] !== 1'b1) begin errors++;
      $display("[TB] FAIL waw_dual_wb_left1: got %b expected 1", bus.qry_busy[0]); end
    bus.wb_valid[0] = 1'b1; bus.wb_addr[0] = 5'd3;
    tick();
    idle();
    #1;
    checks++; if ({bus.busy_vec, bus.err_underflow} !== 33'h0) begin errors++;
      $display("[TB] FAIL waw_drained: got busy %h err %b expected 00000000 0",
               bus.busy_vec, bus.err_underflow); end
  endtask

  task automatic test_back_to_back();
    issue_to(5'd9);
    issue_to(5'd9);
    bus.issue_valid = 1'b1; bus.issue_wr = 1'b1; bus.issue_rd = 5'd9;
    bus.wb_valid = 2'b11; bus.wb_addr[0] = 5'd9; bus.wb_addr[1] = 5'd9;
    #1;
    checks++; if (bus.issue_accept !== 1'b1) begin errors++;
      $display("[TB] FAIL b2b_accept: got %b expected 1", bus.issue_accept); end
    tick();
    idle();
    bus.qry_addr[1] = 5'd9;
    #1;
    checks++; if (bus.qry_busy !== 3'b010) begin errors++;
      $display("[TB] FAIL b2b_cnt9_is1: got %b expected 010", bus.qry_busy); end
    bus.wb_valid[0] = 1'b1; bus.wb_addr[0] = 5'd9;
    tick();
    idle();
    #1;
    checks++; if ({bus.busy_vec, bus.err_underflow} !== 33'h0) begin errors++;
      $display("[TB] FAIL b2b_cnt9_zero: got busy %h err %b expected 00000000 0",
               bus.busy_vec, bus.err_underflow); end
    issue_to(5'd1);
    issue_to(5'd2);
    bus.wb_valid = 2'b11; bus.wb_addr[0] = 5'd1; bus.wb_addr[1] = 5'd2;
    #1;
    checks++; if (bus.busy_vec !== 32'h0000_0006) begin errors++;
      $display("[TB] FAIL b2b_two_regs_busy: got %h expected 00000006", bus.busy_vec); end
    tick();
    idle();
    #1;
    checks++; if (bus.busy_vec !== 32'h0) begin errors++;
      $display("[TB] FAIL b2b_two_regs_clear: got %h expected 00000000", bus.busy_vec); end
  endtask

  task automatic test_underflow();
    bus.wb_valid[1] = 1'b1; bus.wb_addr[1] = 5'd12;
    #1;
    checks++; if (bus.err_underflow !== 1'b0) begin errors++;
      $display("[TB] FAIL uf_before: got %b expected 0", bus.err_underflow); end
    tick();
    idle();
    #1;
    checks++; if ({bus.busy_vec, bus.err_underflow} !== 33'h1) begin errors++;
      $display("[TB] FAIL uf_set: got busy %h err %b expected 00000000 1",
               bus.busy_vec, bus.err_underflow); end
    bus.flush = 1'b1;
    tick();
    idle();
    #1;
    checks++; if (bus.err_underflow !== 1'b1) begin errors++;
      $display("[TB] FAIL uf_after_flush: got %b expected 1", bus.err_underflow); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++; if (bus.err_underflow !== 1'b0) begin errors++;
      $display("[TB] FAIL uf_after_reset: got %b expected 0", bus.err_underflow); end
  endtask

  task automatic test_flush();
    issue_to(5'd4);
    issue_to(5'd10);
    issue_to(5'd4);
    #1;
    checks++; if (bus.busy_vec !== 32'h0000_0410) begin errors++;
      $display("[TB] FAIL flush_pre_busy: got %h expected 00000410", bus.busy_vec); end
    bus.flush = 1'b1;
    bus.issue_valid = 1'b1; bus.issue_wr = 1'b1; bus.issue_rd = 5'd6;
    bus.wb_valid[0] = 1'b1; bus.wb_addr[0] = 5'd4;
    #1;
    checks++; if ({bus.stall, bus.issue_accept} !== 2'b00) begin errors++;
      $display("[TB] FAIL flush_accept: got stall/accept %b expected 00",
               {bus.stall, bus.issue_accept}); end
    tick();
    idle();
    #1;
    checks++; if ({bus.busy_vec, bus.err_underflow} !== 33'h0) begin errors++;
      $display("[TB] FAIL flush_cleared: got busy %h err %b expected 00000000 0",
               bus.busy_vec, bus.err_underflow); end
  endtask

  task automatic test_zero_hw();
    bus_z.issue_valid = 1'b1; bus_z.issue_wr = 1'b1; bus_z.issue_rd = 5'd0;
    bus.issue_valid = 1'b1;   bus.issue_wr = 1'b1;   bus.issue_rd = 5'd0;
    #1;
    checks++; if (bus_z.issue_accept !== 1'b1) begin errors++;
      $display("[TB] FAIL zhw_accept: got %b expected 1", bus_z.issue_accept); end
    tick();
    idle();
    #1;
    checks++; if (bus_z.busy_vec !== 32'h0) begin errors++;
      $display("[TB] FAIL zhw_x0_not_busy: got %h expected 00000000", bus_z.busy_vec); end
    checks++; if (bus.busy_vec !== 32'h0000_0001) begin errors++;
      $display("[TB] FAIL zhw_f0_tracked: got %h expected 00000001", bus.busy_vec); end
    bus_z.wb_valid[0] = 1'b1; bus_z.wb_addr[0] = 5'd0;
    bus.wb_valid[0] = 1'b1;   bus.wb_addr[0] = 5'd0;
    tick();
    idle();
    #1;
    checks++; if (bus_z.err_underflow !== 1'b0) begin errors++;
      $display("[TB] FAIL zhw_x0_no_underflow: got %b expected 0", bus_z.err_underflow); end
    checks++; if ({bus.busy_vec, bus.err_underflow} !== 33'h0) begin errors++;
      $display("[TB] FAIL zhw_f0_retired: got busy %h err %b expected 00000000 0",
               bus.busy_vec, bus.err_underflow); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_issue_wb();
    test_src_block();
    test_waw_limit();
    test_back_to_back();
    test_underflow();
    test_flush();
    test_zero_hw();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_scoreboard_ctr.md
# fp_scoreboard_ctr

Parametrised register-busy scoreboard for the integer and floating-point register files. It tracks outstanding writes per architectural register with saturating pending counters instead of single busy bits, so several in-flight writers to one register (WAW) are allowed. It accepts multiple write-back ports per cycle and supports a pipeline flush. It sits between decode (issue side) and the write-back/commit mux, and produces the decode stall plus per-register busy status for the RAW/WAW units.

## Interface
Parameters:
- TOTAL_REGS, 32, architectural registers tracked; power of two, at least 2.
- NUM_SRCS, 3, source operand checks per issue (rs1, rs2, rs3).
- NUM_WB, 2, write-back ports that can retire a write each cycle.
- CNT_W, 2, pending-counter width; a register has at most 2^CNT_W-1 outstanding writers.
- NUM_QRY, 3, lookup ports for clear logic (the uu_rd checks).
- ZERO_HARDWIRED, 0, 1 means register 0 is never tracked (integer x0); 0 means register 0 is tracked (f0).

Ports (AW = $clog2(TOTAL_REGS)):
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  clears all counters (squash of in-flight writers).
- issue_valid  in  1  the decode-stage instruction is presented.
- issue_wr  in  1  the instruction writes this register file.
- issue_rd  in  AW  destination address.
- src_addr  in  [NUM_SRCS][AW]  source addresses.
- src_used  in  [NUM_SRCS]  the source is actually read (for example, rs3 only for R4).
- src_fwd  in  [NUM_SRCS][2]  forward select from EXE; non-zero means the operand is bypassed.
- wb_valid  in  [NUM_WB]  the write-back port retires a write.
- wb_addr  in  [NUM_WB][AW]  write-back addresses.
- qry_addr  in  [NUM_QRY][AW]  lookup addresses.
- issue_accept  out  1  the issue is taken this cycle.
- stall  out  1  decode must hold.
- no_dependency  out  1  no used source has a non-zero counter, ignoring forwarding.
- busy_vec  out  TOTAL_REGS  bit r is 1 when cnt[r] is non-zero.
- qry_busy  out  [NUM_QRY]  the busy bit of each qry_addr.
- err_underflow  out  1  sticky; a write-back hit a zero counter.

## Operation
- State is cnt[r] (CNT_W bits) for each r, plus err_underflow. Every output is derived combinationally from registered state and the current inputs.
- Source j is blocking when src_used[j], cnt[src_addr[j]] is non-zero, and src_fwd[j] is 0.
- WAW limit: full_rd is true when issue_wr is high and cnt[issue_rd] equals 2^CNT_W-1.
- stall = issue_valid AND (any source blocking OR full_rd).
- issue_accept = issue_valid AND NOT stall AND NOT flush.
- Increment: inc[r] = issue_accept AND issue_wr AND issue_rd==r.
- Decrement: dec[r] = the number of ports k with wb_valid[k] and wb_addr[k]==r, ranging 0..NUM_WB.
- Next-state value: cnt[r] + inc[r] - dec[r], computed at CNT_W+2 bits.
  - A negative result clamps to 0 and sets err_underflow.
  - The result never exceeds the maximum, because the full_rd stall prevents it.
- If ZERO_HARDWIRED=1:
  - cnt[0] stays 0.
  - Register 0 never blocks and never underflows.
- Priority: reset, then flush, then normal update.
  - flush zeroes every counter.
  - flush leaves err_underflow unchanged.
  - Issue and write-back during a flush cycle are discarded.
- Only reset clears err_underflow.

## Timing
- Reset (sampled on the clk edge) gives:
  - all cnt = 0;
  - err_underflow = 0;
  - busy_vec = 0, qry_busy = 0, no_dependency = 1;
  - stall = 0, and issue_accept = issue_valid.
- An issue accepted at edge N makes busy visible from cycle N+1.
- A write-back in cycle N makes not-busy visible from cycle N+1. There is no same-cycle write-back bypass; the EXE forward path covers that case.
- An issue and a write-back to the same register in the same cycle give a net-zero counter change.
- NUM_WB write-backs to the same register in one cycle decrement by NUM_WB.
- stall and issue_accept depend combinationally on issue and source inputs; they have no internal registers.
- Reset or flush asserted mid-operation takes effect at the next edge, regardless of other inputs.

## Test plan
- Reset, then issue rd=5 with issue_wr=1 and no sources → issue_accept=1; at the next cycle busy_vec[5]=1. Write-back wb_addr=5 → busy_vec[5]=0 one cycle later.
- cnt[7]=1, src_addr[0]=7, src_used[0]=1:
  - with src_fwd[0]=0 → stall=1, issue_accept=0;
  - with src_fwd[0]=2'b01 → stall=0;
  - with src_used[0]=0 → stall=0, no_dependency=1.
- CNT_W=2, three accepted issues to rd=3 → cnt[3]=3. A fourth issue to rd=3 → stall=1 (full_rd). One write-back to 3 → the next issue is accepted.
- cnt[9]=2, both write-back ports at 9 plus an accepted issue to 9 in the same cycle → cnt[9]=1. A write-back to a zero register → err_underflow=1, persisting after flush and cleared only by reset.
- Several counters non-zero, flush=1 with issue_valid=1 → issue_accept=0; the next cycle busy_vec=0. With ZERO_HARDWIRED=1, an issue to rd=0 leaves busy_vec[0]=0.
